// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and helpers for
// the mem_access_ctrl block RAM controller.
package mem_ctrl_pkg;

  typedef enum logic {
    SERVE = 1'b0,
    SWEEP = 1'b1
  } ctrl_state_e;

  localparam int DEPTH_DFLT = 1024;

  // Extra bit so the final sweep index never aliases 0.
  localparam int SWEEP_CNT_W_DFLT = $clog2(DEPTH_DFLT) + 1;

  function automatic int unsigned sweep_cnt_w(
    input int unsigned depth
  );
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned rr_next(
    input int unsigned win,
    input int unsigned n
  );
    return (win == n - 1) ? 0 : win + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with an
// internal pointer that moves past each winner.
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic          found;

  always_comb begin
    gnt   = '0;
    win   = '0;
    idx   = '0;
    sum   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N))
        sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= '0;
    else if (found)
      ptr <= PW'(rr_next(32'(win), N));
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: N-requester front end for a
// read-first simple-dual-port RAM with a fill sweep.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WID_MEM   = 16,
  parameter int DEPTH_MEM = DEPTH_DFLT,
  parameter int ADDR_W    = 32,
  parameter int N_REQ     = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ-1:0]                req_we,
  input  logic [N_REQ-1:0][ADDR_W-1:0]    req_addr,
  input  logic [N_REQ-1:0][WID_MEM-1:0]   req_wdata,
  output logic [N_REQ-1:0]                req_ready,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic                            rsp_err,
  output logic [WID_MEM-1:0]              rsp_rdata,
  output logic [ADDR_W-1:0]               mem_raddr,
  output logic [ADDR_W-1:0]               mem_waddr,
  output logic [WID_MEM-1:0]              mem_din,
  output logic                            mem_we,
  input  logic [WID_MEM-1:0]              mem_dout,
  input  logic                            sweep_start,
  input  logic [WID_MEM-1:0]              sweep_value,
  output logic                            sweep_busy,
  output logic                            sweep_done
);

  localparam int CNT_W = sweep_cnt_w(DEPTH_MEM);
  localparam logic [ADDR_W-1:0] LIM =
    ADDR_W'(DEPTH_MEM);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEPTH_MEM - 1);

  ctrl_state_e state, state_n;

  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WID_MEM-1:0] fill, fill_n;
  logic               done_n;
  logic               serve;

  logic [N_REQ-1:0]   rd_req, wr_req;
  logic [N_REQ-1:0]   rd_gnt, wr_gnt;
  logic [ADDR_W-1:0]  rd_addr, wr_addr;
  logic [WID_MEM-1:0] wr_data;
  logic               rd_ok, rd_bad, wr_ok;

  logic [ADDR_W-1:0]  raddr_q, waddr_q;
  logic [WID_MEM-1:0] din_q;
  logic [N_REQ-1:0]   rsp_q;
  logic               err_q;

  assign serve  = (state == SERVE);
  assign rd_req = req_valid & ~req_we
                & {N_REQ{serve}};
  assign wr_req = req_valid & req_we
                & {N_REQ{serve}};

  rr_arbiter #(.N(N_REQ)) u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .req   (rd_req),
    .gnt   (rd_gnt)
  );

  rr_arbiter #(.N(N_REQ)) u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .req   (wr_req),
    .gnt   (wr_gnt)
  );

  assign req_ready = rd_gnt | wr_gnt;

  always_comb begin
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rd_gnt[i])
        rd_addr = req_addr[i];
      if (wr_gnt[i]) begin
        wr_addr = req_addr[i];
        wr_data = req_wdata[i];
      end
    end
  end

  // Out-of-range requests complete without touching the RAM.
  assign rd_ok  = (|rd_gnt) && (rd_addr < LIM);
  assign rd_bad = (|rd_gnt) && !(rd_addr < LIM);
  assign wr_ok  = (|wr_gnt) && (wr_addr < LIM);

  assign mem_raddr = rd_ok ? rd_addr : raddr_q;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    fill_n    = fill;
    done_n    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = waddr_q;
    mem_din   = din_q;
    unique case (state)
      SERVE: begin
        if (wr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_din   = wr_data;
        end
        if (sweep_start) begin
          state_n = SWEEP;
          cnt_n   = '0;
          fill_n  = sweep_value;
        end
      end
      SWEEP: begin
        mem_we    = 1'b1;
        mem_waddr = ADDR_W'(cnt);
        mem_din   = fill;
        cnt_n     = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = SERVE;
          done_n  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SERVE;
      cnt        <= '0;
      fill       <= '0;
      sweep_done <= 1'b0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      din_q      <= '0;
      rsp_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      fill       <= fill_n;
      sweep_done <= done_n;
      raddr_q    <= mem_raddr;
      waddr_q    <= mem_waddr;
      din_q      <= mem_din;
      rsp_q      <= rd_gnt;
      err_q      <= rd_bad;
    end
  end

  assign sweep_busy = (state == SWEEP);
  assign rsp_valid  = rsp_q;
  assign rsp_err    = err_q;
  assign rsp_rdata  = ((|rsp_q) && !err_q)
                    ? mem_dout : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of arbitration,
// read latency, range errors and the fill sweep.
module tb_mem_access_ctrl;

  logic              clk;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_we;
  logic [1:0][31:0]  req_addr;
  logic [1:0][15:0]  req_wdata;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic              rsp_err;
  logic [15:0]       rsp_rdata;
  logic [31:0]       mem_raddr;
  logic [31:0]       mem_waddr;
  logic [15:0]       mem_din;
  logic              mem_we;
  logic [15:0]       mem_dout;
  logic              sweep_start;
  logic [15:0]       sweep_value;
  logic              sweep_busy;
  logic              sweep_done;

  int checks;
  int failures;

  logic [15:0] ram [1024];

  mem_access_ctrl #(
    .WID_MEM   (16),
    .DEPTH_MEM (1024),
    .ADDR_W    (32),
    .N_REQ     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .mem_raddr   (mem_raddr),
    .mem_waddr   (mem_waddr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .mem_dout    (mem_dout),
    .sweep_start (sweep_start),
    .sweep_value (sweep_value),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first simple-dual-port RAM with registered output.
  always @(posedge clk) begin
    if (mem_we && mem_waddr < 32'd1024)
      ram[mem_waddr[9:0]] <= mem_din;
    mem_dout <= ram[mem_raddr[9:0]];
  end

  task automatic rd(
    input  bit          r,
    input  logic [31:0] a,
    output logic        acc,
    output logic        v,
    output logic [15:0] d,
    output logic        e
  );
    @(negedge clk);
    req_valid    = 2'b00;
    req_valid[r] = 1'b1;
    req_we[r]    = 1'b0;
    req_addr[r]  = a;
    #1 acc = req_ready[r];
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    v = rsp_valid[r];
    d = rsp_rdata;
    e = rsp_err;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 ||
        rsp_err !== 1'b0 || rsp_rdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_rsp ready=%b vld=%b err=%b rdata=%h exp 00/00/0/0000",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_raddr !== 32'd0 ||
        mem_waddr !== 32'd0 || mem_din !== 16'h0) begin
      failures++;
      $display("FAIL reset_mem we=%b ra=%h wa=%h din=%h exp 0/0/0/0",
               mem_we, mem_raddr, mem_waddr, mem_din);
    end
    checks++;
    if (sweep_busy !== 1'b0 || sweep_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_sweep busy=%b done=%b exp 0/0",
               sweep_busy, sweep_done);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    req_valid    = 2'b01;
    req_we       = 2'b01;
    req_addr[0]  = 32'd5;
    req_wdata[0] = 16'hBEEF;
    #1 checks++;
    if (req_ready !== 2'b01 || mem_we !== 1'b1 ||
        mem_waddr !== 32'd5 || mem_din !== 16'hBEEF) begin
      failures++;
      $display("FAIL wr_issue ready=%b we=%b wa=%0d din=%h exp 01/1/5/beef",
               req_ready, mem_we, mem_waddr, mem_din);
    end
    @(negedge clk);
    req_valid   = 2'b10;
    req_we      = 2'b00;
    req_addr[1] = 32'd5;
    #1 checks++;
    if (req_ready !== 2'b10 || mem_raddr !== 32'd5 ||
        mem_we !== 1'b0 || mem_waddr !== 32'd5) begin
      failures++;
      $display("FAIL rd_issue ready=%b ra=%0d we=%b wa=%0d exp 10/5/0/5",
               req_ready, mem_raddr, mem_we, mem_waddr);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 16'hBEEF ||
        rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rd_rsp vld=%b rdata=%h err=%b exp 10/beef/0",
               rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_rr_read();
    logic [1:0] exp;
    @(negedge clk);
    req_valid   = 2'b11;
    req_we      = 2'b00;
    req_addr[0] = 32'd20;
    req_addr[1] = 32'd21;
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1 checks++;
      if (req_ready !== exp ||
          mem_raddr !== ((i % 2 == 0) ? 32'd20 : 32'd21)) begin
        failures++;
        $display("FAIL rr_rd_gnt%0d ready=%b ra=%0d exp %b",
                 i, req_ready, mem_raddr, exp);
      end
      if (i > 0) begin
        checks++;
        if (rsp_valid !== ~exp) begin
          failures++;
          $display("FAIL rr_rd_rsp%0d vld=%b exp %b",
                   i, rsp_valid, ~exp);
        end
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_rr_write();
    logic [1:0]  exp;
    logic        acc, v, e;
    logic [15:0] d;
    @(negedge clk);
    req_valid    = 2'b11;
    req_we       = 2'b11;
    req_addr[0]  = 32'd40;
    req_wdata[0] = 16'h1111;
    req_addr[1]  = 32'd41;
    req_wdata[1] = 16'h2222;
    // Write pointer sits at 1 after the earlier req0 write.
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1 checks++;
      if (req_ready !== exp || mem_we !== 1'b1 ||
          mem_waddr !== ((i % 2 == 0) ? 32'd41 : 32'd40)) begin
        failures++;
        $display("FAIL rr_wr_gnt%0d ready=%b we=%b wa=%0d exp %b",
                 i, req_ready, mem_we, mem_waddr, exp);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    rd(1'b0, 32'd40, acc, v, d, e);
    checks++;
    if (!acc || v !== 1'b1 || d !== 16'h1111 || e !== 1'b0) begin
      failures++;
      $display("FAIL rr_wr_data40 acc=%b vld=%b rdata=%h exp 1/1/1111",
               acc, v, d);
    end
    rd(1'b1, 32'd41, acc, v, d, e);
    checks++;
    if (!acc || v !== 1'b1 || d !== 16'h2222 || e !== 1'b0) begin
      failures++;
      $display("FAIL rr_wr_data41 acc=%b vld=%b rdata=%h exp 1/1/2222",
               acc, v, d);
    end
  endtask

  task automatic test_same_cycle();
    logic        acc, v, e;
    logic [15:0] d;
    @(negedge clk);
    req_valid    = 2'b11;
    req_we       = 2'b01;
    req_addr[0]  = 32'd9;
    req_wdata[0] = 16'h1234;
    req_addr[1]  = 32'd9;
    #1 checks++;
    if (req_ready !== 2'b11 || mem_we !== 1'b1 ||
        mem_waddr !== 32'd9 || mem_raddr !== 32'd9) begin
      failures++;
      $display("FAIL same_issue ready=%b we=%b wa=%0d ra=%0d exp 11/1/9/9",
               req_ready, mem_we, mem_waddr, mem_raddr);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 16'h0000 ||
        rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL same_old vld=%b rdata=%h err=%b exp 10/0000/0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    rd(1'b1, 32'd9, acc, v, d, e);
    checks++;
    if (!acc || v !== 1'b1 || d !== 16'h1234 || e !== 1'b0) begin
      failures++;
      $display("FAIL same_new acc=%b vld=%b rdata=%h exp 1/1/1234",
               acc, v, d);
    end
  endtask

  task automatic test_sweep();
    int          nb;
    int          nd;
    logic        seq_bad;
    logic        rdy_bad;
    logic        acc, v, e;
    logic [15:0] d;
    nb      = 0;
    nd      = 0;
    seq_bad = 1'b0;
    rdy_bad = 1'b0;
    @(negedge clk);
    sweep_value = 16'hA5A5;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    req_valid   = 2'b10;
    req_we      = 2'b00;
    req_addr[1] = 32'd0;
    for (int c = 0; c < 1200; c++) begin
      #1;
      if (sweep_busy) begin
        if (mem_we !== 1'b1 || mem_waddr !== nb ||
            mem_din !== 16'hA5A5)
          seq_bad = 1'b1;
        if (req_ready !== 2'b00)
          rdy_bad = 1'b1;
        nb++;
      end
      if (sweep_done)
        nd++;
      if (!sweep_busy)
        break;
      // A second start mid-sweep must not restart it.
      sweep_start = (nb == 100);
      sweep_value = (nb == 100) ? 16'h0000 : 16'hA5A5;
      @(negedge clk);
    end
    checks++;
    if (nb != 1024) begin
      failures++;
      $display("FAIL sweep_busy_len got=%0d exp 1024", nb);
    end
    checks++;
    if (nd != 1 || sweep_done !== 1'b1) begin
      failures++;
      $display("FAIL sweep_done pulses=%0d now=%b exp 1/1",
               nd, sweep_done);
    end
    checks++;
    if (seq_bad !== 1'b0 || rdy_bad !== 1'b0) begin
      failures++;
      $display("FAIL sweep_seq seq_bad=%b rdy_bad=%b exp 0/0",
               seq_bad, rdy_bad);
    end
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL sweep_exit_accept ready=%b exp 10", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 16'hA5A5 ||
        sweep_done !== 1'b0) begin
      failures++;
      $display("FAIL sweep_a0 vld=%b rdata=%h done=%b exp 10/a5a5/0",
               rsp_valid, rsp_rdata, sweep_done);
    end
    rd(1'b0, 32'd511, acc, v, d, e);
    checks++;
    if (!acc || v !== 1'b1 || d !== 16'hA5A5 || e !== 1'b0) begin
      failures++;
      $display("FAIL sweep_a511 acc=%b vld=%b rdata=%h exp 1/1/a5a5",
               acc, v, d);
    end
    rd(1'b1, 32'd1023, acc, v, d, e);
    checks++;
    if (!acc || v !== 1'b1 || d !== 16'hA5A5 || e !== 1'b0) begin
      failures++;
      $display("FAIL sweep_a1023 acc=%b vld=%b rdata=%h exp 1/1/a5a5",
               acc, v, d);
    end
  endtask

  task automatic test_out_of_range();
    logic        acc, v, e;
    logic [15:0] d;
    @(negedge clk);
    req_valid    = 2'b11;
    req_we       = 2'b01;
    req_addr[0]  = 32'd2000;
    req_wdata[0] = 16'hDEAD;
    req_addr[1]  = 32'd1024;
    #1 checks++;
    if (req_ready !== 2'b11 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL oor_issue ready=%b we=%b exp 11/0",
               req_ready, mem_we);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 ||
        rsp_rdata !== 16'h0000) begin
      failures++;
      $display("FAIL oor_rsp vld=%b err=%b rdata=%h exp 10/1/0000",
               rsp_valid, rsp_err, rsp_rdata);
    end
    rd(1'b1, 32'd976, acc, v, d, e);
    checks++;
    if (!acc || v !== 1'b1 || d !== 16'hA5A5 || e !== 1'b0) begin
      failures++;
      $display("FAIL oor_alias acc=%b vld=%b rdata=%h err=%b exp 1/1/a5a5/0",
               acc, v, d, e);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic        hit;
    logic        acc, v, e;
    logic [15:0] d;
    logic [31:0] addrs [4];
    logic [15:0] exps  [4];
    addrs = '{32'd0, 32'd299, 32'd300, 32'd1023};
    exps  = '{16'h5A5A, 16'h5A5A, 16'hA5A5, 16'hA5A5};
    hit = 1'b0;
    @(negedge clk);
    sweep_value = 16'h5A5A;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (sweep_busy && mem_waddr == 32'd300) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rst_sweep_reach hit=%b exp 1", hit);
    end
    reset = 1'b0;
    #1 checks++;
    if (sweep_busy !== 1'b0 || sweep_done !== 1'b0 ||
        mem_we !== 1'b0 || mem_waddr !== 32'd0 ||
        mem_din !== 16'h0 || mem_raddr !== 32'd0) begin
      failures++;
      $display("FAIL rst_sweep_out busy=%b done=%b we=%b wa=%h din=%h ra=%h exp all 0",
               sweep_busy, sweep_done, mem_we, mem_waddr,
               mem_din, mem_raddr);
    end
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 ||
        rsp_err !== 1'b0 || rsp_rdata !== 16'h0) begin
      failures++;
      $display("FAIL rst_sweep_rsp ready=%b vld=%b err=%b rdata=%h exp 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 checks++;
    if (sweep_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_sweep_state busy=%b exp 0", sweep_busy);
    end
    for (int k = 0; k < 4; k++) begin
      rd(k[0], addrs[k], acc, v, d, e);
      checks++;
      if (!acc || v !== 1'b1 || d !== exps[k] || e !== 1'b0) begin
        failures++;
        $display("FAIL rst_sweep_a%0d acc=%b vld=%b rdata=%h exp 1/1/%h",
                 addrs[k], acc, v, d, exps[k]);
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    req_valid   = 2'b00;
    req_we      = 2'b00;
    req_addr    = '0;
    req_wdata   = '0;
    sweep_start = 1'b0;
    sweep_value = 16'h0;
    for (int i = 0; i < 1024; i++)
      ram[i] = 16'h0;
    test_reset();
    test_write_read();
    test_rr_read();
    test_rr_write();
    test_same_cycle();
    test_sweep();
    test_out_of_range();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Controller between N_REQ requesters and one simple-dual-port block RAM: the registered-read RAM with separate raddr/waddr/din/dout, plus a write enable (mem_we) on its instance.
- Arbitrates the read port and the write port independently, round-robin, so one read and one write can issue in the same cycle.
- Contains a sweep engine that rewrites every RAM word with a runtime value, giving re-initialisation without reloading the init file.

Parameters:
- WID_MEM, 16, RAM word width.
- DEPTH_MEM, 1024, RAM depth in words.
- ADDR_W, 32, address width on requester and RAM ports.
- N_REQ, 2, number of requesters (minimum 2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  request valid, one bit per requester.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ x ADDR_W  word address.
- req_wdata  in  N_REQ x WID_MEM  write data.
- req_ready  out  N_REQ  request accepted this cycle.
- rsp_valid  out  N_REQ  read data valid; one-hot or zero.
- rsp_err  out  1  qualifies rsp_valid: address was out of range.
- rsp_rdata  out  WID_MEM  read data, shared by all requesters.
- mem_raddr  out  ADDR_W  to RAM raddr.
- mem_waddr  out  ADDR_W  to RAM waddr.
- mem_din  out  WID_MEM  to RAM din.
- mem_we  out  1  RAM write enable.
- mem_dout  in  WID_MEM  from RAM dout; registered, 1-cycle latency.
- sweep_start  in  1  pulse: start re-initialisation.
- sweep_value  in  WID_MEM  fill value, sampled on sweep_start.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset state: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_raddr=0, mem_waddr=0, mem_din=0, sweep_busy=0, sweep_done=0. Round-robin pointers=0, state=SERVE.
- Request handshake: transfer when req_valid & req_ready. req_ready is combinational from req_valid and state. A requester keeps its request stable until accepted.
- Channel split: requesters with req_we=1 compete for the write channel; req_we=0 for the read channel.
- Grant rule: per channel, the first valid requester at or after that channel's pointer wins. On a grant the pointer moves to winner+1 mod N_REQ; with no grant it holds. At most one grant per channel per cycle.
- Write grant: mem_we=1, mem_waddr/mem_din driven combinationally from the winner, same cycle.
- Read grant: mem_raddr driven the same cycle. The next cycle asserts rsp_valid[winner], with rsp_rdata=mem_dout. Read latency is exactly 1 cycle after acceptance; no back-pressure on responses.
- Same-address read and write in one cycle: the read returns the old data (RAM is read-first). The controller does not forward.
- Out-of-range address (addr >= DEPTH_MEM):
  - Accepted normally.
  - Write: mem_we stays 0.
  - Read: RAM not read; next cycle rsp_valid with rsp_err=1, rsp_rdata=0.
- State machine, SERVE -> SWEEP on sweep_start: capture sweep_value, counter=0. sweep_start is ignored while in SWEEP.
- SWEEP behaviour:
  - All req_ready=0.
  - Each cycle: mem_we=1, mem_waddr=counter, mem_din=captured value, counter++.
  - A read accepted in the cycle before entry still returns its response.
- SWEEP -> SERVE after the write to DEPTH_MEM-1. sweep_busy is high for exactly DEPTH_MEM cycles. sweep_done pulses in the first SERVE cycle. Requests are accepted in that same cycle.
- Counter width: clog2(DEPTH_MEM)+1 bits, so no wrap ambiguity.
- Pointers: wrap N_REQ-1 -> 0.
- Reset mid-sweep aborts immediately. RAM keeps the partially written contents; no restoration.
- When there is no write grant and no sweep, mem_we=0 and mem_waddr/mem_din hold their previous values.

Decomposition:
- Package mem_ctrl_pkg:
  - typedef ctrl_state_e {SERVE, SWEEP}.
  - Function for next round-robin pointer.
  - Localparam for the counter width.
- Sub-module rr_arbiter (N_REQ request vector in, one-hot grant out, pointer register inside). Instantiated twice: read channel and write channel.

Test Plan:
- Req0 writes 0xBEEF at addr 5; next cycle req1 reads addr 5 -> rsp_valid[1] one cycle after acceptance, rsp_rdata=0xBEEF, rsp_err=0.
- Both requesters read continuously, different addresses, for 6 cycles -> grants alternate 0,1,0,1,0,1; same pattern on the write channel when both write.
- Same cycle: req0 writes 0x1234 to addr 9 (old 0x0000), req1 reads addr 9 -> both ready=1, read returns 0x0000. A later read returns 0x1234.
- sweep_start with sweep_value=0xA5A5:
  - sweep_busy high for 1024 cycles, all req_ready=0.
  - sweep_done one pulse.
  - Reads of addrs 0, 511, 1023 return 0xA5A5.
- Read addr 1024 and write addr 2000 -> both accepted. mem_we stays 0. Read returns rsp_err=1, rsp_rdata=0. RAM contents unchanged.
- reset low at sweep counter 300 -> all outputs at reset values immediately. After release: SERVE, addrs 0..299 hold the fill value, addr 300+ unchanged.
